// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
// The FSM state encoding, the largest legal BCD digit and the default digit width.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX       = 4'h9;
    localparam int         DEFAULT_NBITS = 4;

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle of the BCD countdown timer.
// master drives the controls and presets, slave is the timer itself.
interface bcd_countdown_timer_if
    import bcd_countdown_timer_pkg::*;
#(
    parameter int NBITS = DEFAULT_NBITS
);
    logic             load;
    logic [NBITS-1:0] preset_u;
    logic [NBITS-1:0] preset_d;
    logic             start;
    logic             stop;
    logic [NBITS-1:0] counter_u;
    logic [NBITS-1:0] counter_d;
    logic             running;
    logic             expired;
    logic             done;

    modport master (
        output load, preset_u, preset_d, start, stop,
        input  counter_u, counter_d, running, expired, done
    );

    modport slave (
        input  load, preset_u, preset_d, start, stop,
        output counter_u, counter_d, running, expired, done
    );
endinterface

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with a saturating parallel load.
// borrow_in is the decrement enable; borrow_out chains into the next more significant digit.
module bcd_digit_down
    import bcd_countdown_timer_pkg::*;
#(
    parameter int NBITS = DEFAULT_NBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [NBITS-1:0] load_val,
    input  logic             borrow_in,
    output logic [NBITS-1:0] digit,
    output logic             borrow_out
);
    localparam logic [NBITS-1:0] DMAX = NBITS'(BCD_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= (load_val > DMAX) ? DMAX : load_val;
        end else if (borrow_in) begin
            digit <= (digit == '0) ? DMAX : digit - NBITS'(1);
        end
    end

    assign borrow_out = (digit == '0) && borrow_in;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer: prescaler-driven tick, IDLE/RUN/PAUSE/DONE control FSM.
// The tick is a clock enable into the digit registers; everything runs on clk.
//
// state | meaning
// IDLE  | count loaded or reset, waiting for start with a non-zero count
// RUN   | prescaler advancing, count decrements once per FRECUENCY cycles
// PAUSE | prescaler and count frozen, start resumes from the held phase
// DONE  | count reached 00, expired high, only load/reset leave
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int NBITS     = DEFAULT_NBITS,
    parameter int FRECUENCY = 10000000
) (
    input logic                  clk,
    input logic                  reset,
    bcd_countdown_timer_if.slave bus
);
    localparam int              PW       = (FRECUENCY > 2) ? $clog2(FRECUENCY) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(FRECUENCY - 1);

    state_t        state;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic          dec_en;
    logic          units_borrow;
    logic          tens_borrow;
    logic          count_zero;
    logic          count_one;

    assign tick       = (state == ST_RUN) && (prescaler == PRE_LAST);
    assign dec_en     = tick && !bus.load && !bus.stop;
    assign count_zero = (bus.counter_d == '0) && (bus.counter_u == '0);
    assign count_one  = (bus.counter_d == '0) && (bus.counter_u == NBITS'(1));

    bcd_digit_down #(.NBITS(NBITS)) u_units (
        .clk        (clk),
        .reset      (reset),
        .load       (bus.load),
        .load_val   (bus.preset_u),
        .borrow_in  (dec_en),
        .digit      (bus.counter_u),
        .borrow_out (units_borrow)
    );

    bcd_digit_down #(.NBITS(NBITS)) u_tens (
        .clk        (clk),
        .reset      (reset),
        .load       (bus.load),
        .load_val   (bus.preset_d),
        .borrow_in  (units_borrow),
        .digit      (bus.counter_d),
        .borrow_out (tens_borrow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            prescaler   <= '0;
            bus.running <= 1'b0;
            bus.expired <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.load) begin
                state       <= ST_IDLE;
                prescaler   <= '0;
                bus.running <= 1'b0;
                bus.expired <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start && !bus.stop && !count_zero) begin
                            state       <= ST_RUN;
                            bus.running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (bus.stop) begin
                            state       <= ST_PAUSE;
                            bus.running <= 1'b0;
                        end else if (tick) begin
                            prescaler <= '0;
                            // a tens borrow-out would mean stepping below 00; stop there too
                            if (count_one || tens_borrow) begin
                                state       <= ST_DONE;
                                bus.running <= 1'b0;
                                bus.expired <= 1'b1;
                                bus.done    <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (bus.start && !bus.stop) begin
                            state       <= ST_RUN;
                            bus.running <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        bus.expired <= 1'b1;
                    end
                    default: begin
                        state       <= ST_IDLE;
                        bus.running <= 1'b0;
                        bus.expired <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
